// File: rtl/arm_mc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_mc_mem_pkg
// Description : Shared constants for the multicycle CPU memory responder.
//               These cover the MMIO select bit, the register offsets and the
//               STATUS bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mc_mem_pkg;

  // Address bit that steers a bus cycle to MMIO (1) or RAM (0).
  localparam int MMIO_SEL_BIT = 31;

  // MMIO register index, taken from i_Address[3:2].
  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLES = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  // STATUS register layout.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 3;
  localparam int STAT_COUNT_W   = 5;

endpackage
`default_nettype wire

// File: rtl/arm_mc_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arm_mc_tx_fifo
// Description : Byte FIFO that holds bytes waiting to be transmitted.
//               Full and empty come from an occupancy counter. A push into a
//               full FIFO is accepted when a pop happens on the same edge.
//               Otherwise the byte is dropped and o_OvfSet pulses.
// Ports       : i_CLK, i_RESET      - clock, synchronous active-high reset
//               i_Push, i_PushData  - push request and byte
//               i_Pop               - pop request (ignored when empty)
//               o_Head              - head byte (0 while empty)
//               o_Count             - occupancy
//               o_Full, o_Empty     - occupancy flags
//               o_OvfSet            - a push was dropped this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module arm_mc_tx_fifo #(
  parameter int TxDepth = 4
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_Push,
  input  logic [7:0]                 i_PushData,
  input  logic                       i_Pop,
  output logic [7:0]                 o_Head,
  output logic [$clog2(TxDepth):0]   o_Count,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic                       o_OvfSet
);

  localparam int PtrW = $clog2(TxDepth);
  localparam int CntW = PtrW + 1;

  logic [7:0]      mem_q [TxDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            w_pop;
  logic            w_push_ok;

  assign o_Empty  = (count_q == '0);
  assign o_Full   = (count_q == CntW'(TxDepth));
  assign o_Count  = count_q;
  // Gate the head so the port reads 0 while nothing is queued. This also
  // covers the cycles after reset, because the storage itself is not reset.
  assign o_Head   = o_Empty ? 8'h00 : mem_q[rd_ptr_q];

  assign w_pop     = i_Pop && !o_Empty;
  // At full, a same-edge pop frees the slot this push needs.
  assign w_push_ok = i_Push && (!o_Full || w_pop);
  assign o_OvfSet  = i_Push && !w_push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (w_pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the occupancy counter decides what is valid.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET && w_push_ok) mem_q[wr_ptr_q] <= i_PushData;
  end

endmodule
`default_nettype wire

// File: rtl/arm_mc_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : arm_mc_memory_responder
// Description : Bus responder for the multicycle CPU's unified memory port.
//               i_Address[31]=0 selects a word RAM that holds instructions
//               and data. i_Address[31]=1 selects MMIO, made up of:
//                 0x0 TXDATA - write pushes a byte into the TX FIFO, reads 0
//                 0x4 STATUS - {count[7:3], overflow, empty, full};
//                              a write with bit2 set clears overflow
//                 0x8 CYCLES - free-running cycle counter; a write loads it
//                 0xC        - reads 0, writes ignored
//               Reads are combinational. Writes take effect on the clock edge.
// Macro       : ARM_MEM_CYCLE_COUNTER_EN - implements the CYCLES counter.
//               When the macro is undefined, CYCLES reads 0 and writes to it
//               are ignored.
// Ports       : i_CLK, i_RESET                     - clock, sync reset
//               i_MemWrite, i_Address, i_WriteData - CPU bus cycle
//               o_ReadData                         - read data for i_Address
//               o_TxData, o_TxValid, i_TxReady     - TX byte stream
// Revision    : 1.0 - initial release
// ============================================================================
module arm_mc_memory_responder
  import arm_mc_mem_pkg::*;
#(
  parameter int    BusWidth = 32,
  parameter int    MemWords = 64,
  parameter int    TxDepth  = 4,
  parameter string InitFile = ""
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  input  logic                i_MemWrite,
  input  logic [BusWidth-1:0] i_Address,
  input  logic [BusWidth-1:0] i_WriteData,
  output logic [BusWidth-1:0] o_ReadData,
  output logic [7:0]          o_TxData,
  output logic                o_TxValid,
  input  logic                i_TxReady
);

  localparam int RamAw = $clog2(MemWords);

  logic                    w_is_mmio;
  mmio_reg_e               w_reg_sel;
  logic [RamAw-1:0]        w_ram_idx;
  logic                    w_ram_we;
  logic                    w_tx_push;
  logic                    w_ovf_clr;
  logic [BusWidth-1:0]     w_status;
  logic [BusWidth-1:0]     w_cycles;
  logic                    w_unused;

  logic [BusWidth-1:0]     ram_q [MemWords];
  logic                    ovf_q, ovf_d;

  logic [7:0]              fifo_head;
  logic [$clog2(TxDepth):0] fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_ovf_set;

  // Upper and lower address bits alias by design.
  assign w_unused  = ^{i_Address, i_WriteData};

  assign w_is_mmio = i_Address[MMIO_SEL_BIT];
  assign w_reg_sel = mmio_reg_e'(i_Address[3:2]);
  assign w_ram_idx = i_Address[RamAw+1:2];

  assign w_ram_we  = i_MemWrite && !w_is_mmio;
  assign w_tx_push = i_MemWrite && w_is_mmio && (w_reg_sel == REG_TXDATA);
  assign w_ovf_clr = i_MemWrite && w_is_mmio && (w_reg_sel == REG_STATUS)
                     && i_WriteData[STAT_OVF_BIT];

  // -------------------------------------------------------------------------
  // Word RAM (not reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (w_ram_we) ram_q[w_ram_idx] <= i_WriteData;
  end

  // -------------------------------------------------------------------------
  // TX FIFO and sticky overflow
  // -------------------------------------------------------------------------
  arm_mc_tx_fifo #(
    .TxDepth (TxDepth)
  ) u_tx_fifo (
    .i_CLK      (i_CLK),
    .i_RESET    (i_RESET),
    .i_Push     (w_tx_push),
    .i_PushData (i_WriteData[7:0]),
    .i_Pop      (i_TxReady),
    .o_Head     (fifo_head),
    .o_Count    (fifo_count),
    .o_Full     (fifo_full),
    .o_Empty    (fifo_empty),
    .o_OvfSet   (fifo_ovf_set)
  );

  assign o_TxData  = fifo_head;
  assign o_TxValid = !fifo_empty;

  // A drop and a clear cannot share a cycle because each needs its own bus
  // write. Letting set win keeps a drop from ever being lost.
  always_comb begin
    ovf_d = ovf_q;
    if (w_ovf_clr)    ovf_d = 1'b0;
    if (fifo_ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  always_comb begin
    w_status                                 = '0;
    w_status[STAT_FULL_BIT]                  = fifo_full;
    w_status[STAT_EMPTY_BIT]                 = fifo_empty;
    w_status[STAT_OVF_BIT]                   = ovf_q;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
  end

  // -------------------------------------------------------------------------
  // Cycle counter
  // -------------------------------------------------------------------------
`ifdef ARM_MEM_CYCLE_COUNTER_EN
  logic                w_cyc_wr;
  logic [BusWidth-1:0] cycles_q, cycles_d;

  assign w_cyc_wr = i_MemWrite && w_is_mmio && (w_reg_sel == REG_CYCLES);

  // A load on the same edge takes priority over the increment.
  always_comb begin
    cycles_d = cycles_q + BusWidth'(1);
    if (w_cyc_wr) cycles_d = i_WriteData;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  assign w_cycles = cycles_q;
`else
  assign w_cycles = '0;
`endif

  // -------------------------------------------------------------------------
  // Combinational read mux
  // -------------------------------------------------------------------------
  always_comb begin
    o_ReadData = '0;
    if (!w_is_mmio) begin
      o_ReadData = ram_q[w_ram_idx];
    end else begin
      case (w_reg_sel)
        REG_STATUS: o_ReadData = w_status;
        REG_CYCLES: o_ReadData = w_cycles;
        default:    o_ReadData = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_mc_memory_responder
// Description : Self-checking bench for arm_mc_memory_responder. Bus cycles
//               come from a vector table plus hand-written sequences. TX
//               bytes are checked against an expected-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_mc_memory_responder;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_STS = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;
  localparam logic [31:0] A_RSV = 32'h8000_000C;

  logic        i_CLK = 1'b0;
  logic        i_RESET;
  logic        i_MemWrite;
  logic [31:0] i_Address;
  logic [31:0] i_WriteData;
  logic [31:0] o_ReadData;
  logic [7:0]  o_TxData;
  logic        o_TxValid;
  logic        i_TxReady;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  arm_mc_memory_responder dut (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_MemWrite  (i_MemWrite),
    .i_Address   (i_Address),
    .i_WriteData (i_WriteData),
    .o_ReadData  (o_ReadData),
    .o_TxData    (o_TxData),
    .o_TxValid   (o_TxValid),
    .i_TxReady   (i_TxReady)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cyc(input logic [31:0] v);
`ifdef ARM_MEM_CYCLE_COUNTER_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Apply one bus cycle: the inputs change just after a rising edge, and the
  // task returns at the following falling edge so that the caller can sample.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy);
    @(posedge i_CLK);
    #1;
    i_MemWrite  = we;
    i_Address   = a;
    i_WriteData = d;
    i_TxReady   = rdy;
    @(negedge i_CLK);
  endtask

  // Scoreboard: every pop the DUT performs must match the oldest expected byte.
  always @(negedge i_CLK) begin
    if (!i_RESET && o_TxValid && i_TxReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h expected none", o_TxData);
      end else begin
        chk("tx_byte", {24'h0, o_TxData}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         "ram_wr10"};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "ram_rd10"};
    vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,         32'hDEAD_BEEF, "ram_rd110_alias"};
    vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF, "ram_rd12_lowbits"};
    vecs[4]  = '{1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0,         "ram_wr200"};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, "ram_rd0_alias200"};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h0,         "skip"};
    vecs[7]  = '{1'b0, A_TX,          32'h0,         32'h0,         "txdata_rd0"};
    vecs[8]  = '{1'b1, A_RSV,         32'hFFFF_FFFF, 32'h0,         "rsv_wr"};
    vecs[9]  = '{1'b0, A_RSV,         32'h0,         32'h0,         "rsv_rd0"};
    vecs[10] = '{1'b0, A_STS,         32'h0,         32'h0000_0002, "status_empty"};

    i_RESET = 1'b1; i_MemWrite = 1'b0; i_Address = A_CYC;
    i_WriteData = 32'h0; i_TxReady = 1'b0;
    repeat (2) @(posedge i_CLK);
    #1 i_RESET = 1'b0;
    @(negedge i_CLK);

    // ---- reset state and counter ----
    chk("rst_txvalid", {31'h0, o_TxValid}, 32'h0);
    chk("rst_txdata", {24'h0, o_TxData}, 32'h0);
    chk("cyc_0", o_ReadData, exp_cyc(32'd0));
    step(1'b0, A_CYC, 32'h0, 1'b0);
    chk("cyc_1", o_ReadData, exp_cyc(32'd1));
    repeat (4) step(1'b0, A_CYC, 32'h0, 1'b0);
    chk("cyc_5", o_ReadData, exp_cyc(32'd5));
    step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, A_CYC, 32'h0, 1'b0);
    chk("cyc_load", o_ReadData, exp_cyc(32'hFFFF_FFFE));
    step(1'b0, A_CYC, 32'h0, 1'b0);
    chk("cyc_max", o_ReadData, exp_cyc(32'hFFFF_FFFF));
    step(1'b0, A_CYC, 32'h0, 1'b0);
    chk("cyc_wrap", o_ReadData, exp_cyc(32'h0));

    // ---- table-driven RAM / MMIO decode ----
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
      if (!vecs[i].we && vecs[i].name != "skip")
        chk(vecs[i].name, o_ReadData, vecs[i].exp);
    end

    // ---- FIFO fill and overflow ----
    step(1'b1, A_TX, 32'h41, 1'b0);
    exp_q.push_back(8'h41);
    step(1'b0, A_STS, 32'h0, 1'b0);
    chk("sts_after_push", o_ReadData, 32'h0000_0008);
    chk("txvalid_after_push", {31'h0, o_TxValid}, 32'h1);
    for (int b = 8'h42; b <= 8'h45; b++) begin
      step(1'b1, A_TX, 32'(b), 1'b0);
      if (b <= 8'h44) exp_q.push_back(8'(b));
    end
    step(1'b0, A_STS, 32'h0, 1'b0);
    chk("sts_full_ovf", o_ReadData, 32'h0000_0025);
    chk("head_stable", {24'h0, o_TxData}, 32'h41);

    // ---- overflow clear leaves content alone ----
    step(1'b1, A_STS, 32'h0000_0004, 1'b0);
    step(1'b0, A_STS, 32'h0, 1'b0);
    chk("sts_ovf_clr", o_ReadData, 32'h0000_0021);
    chk("head_after_clr", {24'h0, o_TxData}, 32'h41);

    // ---- push at full with a pop on the same edge ----
    exp_q.push_back(8'h55);
    step(1'b1, A_TX, 32'h55, 1'b1);
    step(1'b0, A_STS, 32'h0, 1'b1);
    chk("sts_full_pushpop", o_ReadData, 32'h0000_0021);

    // ---- drain (bounded) ----
    n = 0;
    while (o_TxValid && n < 10) begin
      step(1'b0, A_STS, 32'h0, 1'b1);
      n++;
    end
    chk("drain_bound", 32'(n < 10), 32'h1);
    chk("drain_txvalid", {31'h0, o_TxValid}, 32'h0);
    chk("drain_status", o_ReadData, 32'h0000_0002);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'h0);

    // ---- reset mid-stream ----
    for (int b = 8'h61; b <= 8'h63; b++) begin
      step(1'b1, A_TX, 32'(b), 1'b0);
      exp_q.push_back(8'(b));
    end
    step(1'b0, A_STS, 32'h0, 1'b0);
    chk("sts_three", o_ReadData, 32'h0000_0018);
    @(posedge i_CLK);
    #1;
    i_RESET = 1'b1; i_MemWrite = 1'b1; i_Address = A_TX;
    i_WriteData = 32'h64; i_TxReady = 1'b1;
    @(posedge i_CLK);
    #1;
    i_RESET = 1'b0; i_MemWrite = 1'b0; i_Address = A_STS; i_TxReady = 1'b0;
    exp_q.delete();
    @(negedge i_CLK);
    chk("rst_mid_txvalid", {31'h0, o_TxValid}, 32'h0);
    chk("rst_mid_txdata", {24'h0, o_TxData}, 32'h0);
    chk("rst_mid_status", o_ReadData, 32'h0000_0002);
    step(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk("ram_kept_after_rst", o_ReadData, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
